memory_sp_clr: RTL and testbench
================================

// Module: memory_sp_clr
// PURPOSE
//   Parametrised successor to the VeriRISC single-bus memory: a simple dual-port RAM.
//   Separate write and read ports replace the bidirectional data bus.
//   Read is registered with a valid flag, and a read of the address being written in the same cycle returns the new data.
//   An optional post-reset hardware clear sweep keeps the CPU from fetching stale contents.
//   Sits between the CPU address mux and instruction/data paths; one clock domain.
// PARAMETERS
//   AWIDTH          5     address width; DEPTH = 2**AWIDTH words
//   DWIDTH          8     data word width
//   CLEAR_ON_RESET  1     1: sweep all words to CLEAR_VALUE after reset; 0: contents survive reset
//   CLEAR_VALUE     0     DWIDTH-bit value written by the clear sweep
// PORTS
//   clk     in   1       clock; all state updates on rising edge
//   rst     in   1       synchronous reset, active high
//   wr      in   1       write strobe
//   waddr   in   AWIDTH  write address
//   wdata   in   DWIDTH  write data
//   rd      in   1       read strobe
//   raddr   in   AWIDTH  read address
//   rdata   out  DWIDTH  registered read data
//   rvalid  out  1       rdata holds the result of a read accepted last cycle
//   busy    out  1       clear sweep in progress; wr/rd ignored
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - rdata<=0, rvalid<=0, clr_ptr<=0.
//     - CLEAR_ON_RESET=1: state<=CLEAR, busy<=1.
//     - CLEAR_ON_RESET=0: state<=IDLE, busy<=0; RAM contents untouched.
//   FSM states: CLEAR, IDLE.
//     - CLEAR: each cycle mem[clr_ptr]<=CLEAR_VALUE, clr_ptr<=clr_ptr+1.
//       When clr_ptr==DEPTH-1, the last word is written, state<=IDLE and busy<=0 on that edge.
//       busy is high for exactly DEPTH cycles after rst deasserts.
//     - CLEAR: wr and rd are ignored, rvalid stays 0, rdata holds.
//     - IDLE: no further transitions except via rst.
//   Write (IDLE, wr=1): mem[waddr]<=wdata at posedge.
//   Read (IDLE, rd=1):
//     - rdata<=mem[raddr] and rvalid<=1 at the same posedge; latency 1 cycle.
//     - rd=0: rvalid<=0 and rdata holds its last value.
//   Simultaneous wr and rd:
//     - waddr==raddr: rdata<=wdata (write-first bypass), mem also updated.
//     - waddr!=raddr: ports are independent, and rdata gets the old mem[raddr].
//   Reset mid-sweep restarts the sweep from address 0, taking a full DEPTH cycles.
//   Reset in IDLE with CLEAR_ON_RESET=1 re-clears the whole array.
//   Address arithmetic: clr_ptr is AWIDTH bits, and every address is valid, so there is no out-of-range case.
//   clr_ptr is not used once IDLE is reached.
//   No X on outputs after the first reset edge.
// TESTING (AWIDTH=5, DWIDTH=8 unless stated)
//   1. rst high 1 cycle -> busy=1 for 32 cycles then 0; read 0..31 -> every rdata=8'h00, rvalid=1 one cycle after each rd.
//   2. Write addr 0=8'hFF, addr 31=8'h00; read 0 then 31 -> rdata 8'hFF then 8'h00, each 1 cycle after rd.
//   3. Write data 0..30 to addr 31..1 descending; read addr 31..1 -> data 0..30 in order; rvalid low on idle cycles.
//   4. mem[5]=8'h3C. Then wr=rd=1, waddr=raddr=5, wdata=8'hA5 -> rdata=8'hA5 next cycle.
//      Repeat with raddr=6 (mem[6]=8'h11) -> rdata=8'h11.
//   5. Assert wr (addr 3, 8'h77) and rd during busy -> rvalid stays 0; after sweep, read addr 3 -> 8'h00.
//   6. rst again 10 cycles into sweep -> busy stays high a further 32 cycles.
//      With CLEAR_ON_RESET=0: write addr 7=8'h5A, pulse rst -> rdata=0, rvalid=0, busy=0; read 7 -> 8'h5A.

Source files
------------

// File: rtl/memory_sp_clr.sv
// Simple dual-port RAM with registered read, write-first bypass,
// and an optional post-reset clear sweep.
module memory_sp_clr #(
    parameter int                AWIDTH         = 5,
    parameter int                DWIDTH         = 8,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DWIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [AWIDTH-1:0] clr_ptr;

    logic clearing;
    logic wr_ok;
    logic rd_ok;
    logic bypass;

    assign clearing = (state == S_CLEAR);
    assign wr_ok    = (state == S_IDLE) && wr;
    assign rd_ok    = (state == S_IDLE) && rd;
    assign bypass   = wr && (waddr == raddr);

    // Sweep sequencer: walks clr_ptr over every word once, then idles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
            state   <= DO_CLEAR ? S_CLEAR : S_IDLE;
            busy    <= DO_CLEAR;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Array write: the sweep owns the array while busy, otherwise wr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            unique case (1'b1)
                clearing: mem[clr_ptr] <= CLEAR_VALUE;
                wr_ok:    mem[waddr]   <= wdata;
                default:  ;
            endcase
        end
    end

    // Registered read; same-address write is forwarded to rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (rd_ok) begin
            rdata  <= bypass ? wdata : mem[raddr];
            rvalid <= 1'b1;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_sp_clr.sv
// Bench for memory_sp_clr: vector table, directed corner cases,
// and random traffic against an array-based reference model.
module tb_memory_sp_clr;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic [4:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       rd = 1'b0;
    logic [4:0] raddr = '0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;

    logic       k_rst = 1'b0;
    logic       k_wr = 1'b0;
    logic [4:0] k_waddr = '0;
    logic [7:0] k_wdata = '0;
    logic       k_rd = 1'b0;
    logic [4:0] k_raddr = '0;
    logic [7:0] k_rdata;
    logic       k_rvalid;
    logic       k_busy;

    memory_sp_clr #(
        .AWIDTH(5), .DWIDTH(8),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .wr(wr), .waddr(waddr), .wdata(wdata),
        .rd(rd), .raddr(raddr),
        .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    memory_sp_clr #(
        .AWIDTH(5), .DWIDTH(8),
        .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)
    ) dut_keep (
        .clk(clk), .rst(k_rst),
        .wr(k_wr), .waddr(k_waddr), .wdata(k_wdata),
        .rd(k_rd), .raddr(k_raddr),
        .rdata(k_rdata), .rvalid(k_rvalid), .busy(k_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: contents, pending sweep cycles, read register.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_rdata = '0;
    logic       m_rvalid = 1'b0;
    int         m_left = 0;
    bit         m_on = 1'b0;

    typedef struct {
        logic       w;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       r;
        logic [4:0] ra;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_on     = 1'b1;
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_left   = DEPTH;
            foreach (m_mem[i]) m_mem[i] = 8'h00;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (rd) begin
                m_rvalid = 1'b1;
                if (wr && waddr == raddr) m_rdata = wdata;
                else m_rdata = m_mem[raddr];
            end else begin
                m_rvalid = 1'b0;
            end
            if (wr) m_mem[waddr] = wdata;
        end
        #1;
        if (m_on) begin
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
            chk("model_rdata", 32'(rdata), 32'(m_rdata));
        end
    endtask

    task automatic idle();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic sweep_len(input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk(nm, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        vt.push_back('{1'b1, 5'd0,  8'hFF, 1'b0, 5'd0,  1'b0, 8'h00});
        vt.push_back('{1'b1, 5'd31, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00});
        vt.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 5'd0,  1'b1, 8'hFF});
        vt.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'h00});
        vt.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  1'b0, 8'h00});
        vt.push_back('{1'b1, 5'd5,  8'h3C, 1'b0, 5'd0,  1'b0, 8'h00});
        vt.push_back('{1'b1, 5'd6,  8'h11, 1'b0, 5'd0,  1'b0, 8'h00});
        vt.push_back('{1'b1, 5'd5,  8'hA5, 1'b1, 5'd5,  1'b1, 8'hA5});
        vt.push_back('{1'b1, 5'd5,  8'hA5, 1'b1, 5'd6,  1'b1, 8'h11});
        vt.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 5'd5,  1'b1, 8'hA5});
        vt.push_back('{1'b1, 5'd6,  8'h77, 1'b1, 5'd6,  1'b1, 8'h77});
        vt.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  1'b0, 8'h77});

        // Reset both instances together.
        rst = 1'b1;
        k_rst = 1'b1;
        step();
        rst = 1'b0;
        k_rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        sweep_len("sweep_len_first");

        // Every word reads back as the clear value.
        for (int a = 0; a < DEPTH; a++) begin
            rd = 1'b1;
            raddr = 5'(a);
            step();
            chk("clear_rdata", 32'(rdata), 32'h00);
            chk("clear_rvalid", 32'(rvalid), 32'd1);
        end
        idle();

        // Vector table.
        for (int i = 0; i < vt.size(); i++) begin
            wr = vt[i].w;
            waddr = vt[i].wa;
            wdata = vt[i].wd;
            rd = vt[i].r;
            raddr = vt[i].ra;
            step();
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vt[i].ed));
        end
        idle();

        // Descending-address fill then read back with idle gaps.
        for (int i = 0; i < 31; i++) begin
            wr = 1'b1;
            waddr = 5'(31 - i);
            wdata = 8'(i);
            step();
        end
        idle();
        for (int i = 0; i < 31; i++) begin
            rd = 1'b1;
            raddr = 5'(31 - i);
            step();
            chk("desc_rdata", 32'(rdata), 32'(i));
            rd = 1'b0;
            step();
            chk("desc_gap_rvalid", 32'(rvalid), 32'd0);
        end

        // Traffic during the sweep is ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr = 1'b1;
        waddr = 5'd3;
        wdata = 8'h77;
        rd = 1'b1;
        raddr = 5'd3;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("busy_rvalid", 32'(rvalid), 32'd0);
        end
        chk("busy_end", 32'(busy), 32'd0);
        wr = 1'b0;
        step();
        chk("busy_write_dropped", 32'(rdata), 32'h00);
        chk("busy_write_rvalid", 32'(rvalid), 32'd1);
        idle();

        // Reset in the middle of a sweep restarts it.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_len("sweep_len_restart");

        // Contents survive reset when clearing is disabled.
        k_wr = 1'b1;
        k_waddr = 5'd7;
        k_wdata = 8'h5A;
        step();
        k_wr = 1'b0;
        k_rd = 1'b1;
        k_raddr = 5'd7;
        step();
        chk("keep_pre_rdata", 32'(k_rdata), 32'h5A);
        chk("keep_pre_rvalid", 32'(k_rvalid), 32'd1);
        k_rd = 1'b0;
        k_rst = 1'b1;
        step();
        k_rst = 1'b0;
        chk("keep_rst_rdata", 32'(k_rdata), 32'h00);
        chk("keep_rst_rvalid", 32'(k_rvalid), 32'd0);
        chk("keep_rst_busy", 32'(k_busy), 32'd0);
        k_rd = 1'b1;
        step();
        chk("keep_post_rdata", 32'(k_rdata), 32'h5A);
        chk("keep_post_rvalid", 32'(k_rvalid), 32'd1);
        chk("keep_post_busy", 32'(k_busy), 32'd0);
        k_rd = 1'b0;

        // Random traffic, occasional resets, frequent address collisions.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            wr = 1'($urandom);
            rd = 1'($urandom);
            waddr = 5'($urandom_range(0, 31));
            wdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            else raddr = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
